// File: rtl/cpu_core.sv
// Single-cycle 16-bit processor: eight registers, loadable instruction memory,
// internal data memory, and execution that stops at HALT.
module cpu_core #(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_waddr,
    input  logic [15:0]        imem_wdata,
    output logic               halted,
    output logic [127:0]       reg_state,
    output logic [15:0]        pc
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ALU  = 4'h1,
        OP_ADDI = 4'h2,
        OP_LI   = 4'h3,
        OP_LW   = 4'h4,
        OP_SW   = 4'h5,
        OP_BEQ  = 4'h6,
        OP_BNE  = 4'h7,
        OP_JMP  = 4'h8,
        OP_JR   = 4'h9,
        OP_HALT = 4'hF
    } opcode_e;

    logic [15:0] imem [0:(1<<IMEM_AW)-1];
    logic [15:0] dmem [0:(1<<DMEM_AW)-1];
    logic [15:0] regs [0:7];

    logic [15:0] instr;
    opcode_e     op;
    logic [2:0]  rd, rs, rt, fn;
    logic [15:0] imm6_sx, imm9_sx, imm12_zx;
    logic [15:0] rd_val, rs_val, rt_val;
    logic [15:0] rs_plus_imm, dmem_rdata, branch_target, pc_plus_one;
    logic [15:0] alu_result, wb_data, next_pc;
    logic        wb_en, mem_we;
    logic        unused_addr_bits;

    assign instr    = imem[pc[IMEM_AW-1:0]];
    assign op       = opcode_e'(instr[15:12]);
    assign rd       = instr[11:9];
    assign rs       = instr[8:6];
    assign rt       = instr[5:3];
    assign fn       = instr[2:0];
    assign imm6_sx  = {{10{instr[5]}}, instr[5:0]};
    assign imm9_sx  = {{7{instr[8]}}, instr[8:0]};
    assign imm12_zx = {4'h0, instr[11:0]};

    assign rd_val = regs[rd];
    assign rs_val = regs[rs];
    assign rt_val = regs[rt];

    // Shared adder: ADDI result and LW/SW effective address are the same sum.
    assign rs_plus_imm      = rs_val + imm6_sx;
    assign dmem_rdata       = dmem[rs_plus_imm[DMEM_AW-1:0]];
    assign unused_addr_bits = ^rs_plus_imm[15:DMEM_AW];
    assign pc_plus_one      = pc + 16'd1;
    assign branch_target    = pc_plus_one + imm6_sx;

    assign halted = (instr[15:12] == 4'hF);

    always_comb begin
        alu_result = '0;
        case (fn)
            3'd0: alu_result = rs_val + rt_val;
            3'd1: alu_result = rs_val - rt_val;
            3'd2: alu_result = rs_val & rt_val;
            3'd3: alu_result = rs_val | rt_val;
            3'd4: alu_result = rs_val ^ rt_val;
            3'd5: alu_result = rs_val << rt_val[3:0];
            3'd6: alu_result = rs_val >> rt_val[3:0];
            3'd7: alu_result = {15'd0, $signed(rs_val) < $signed(rt_val)};
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        next_pc = pc_plus_one;
        wb_en   = 1'b0;
        wb_data = '0;
        mem_we  = 1'b0;
        case (op)
            OP_ALU:  begin wb_en = 1'b1; wb_data = alu_result;  end
            OP_ADDI: begin wb_en = 1'b1; wb_data = rs_plus_imm; end
            OP_LI:   begin wb_en = 1'b1; wb_data = imm9_sx;     end
            OP_LW:   begin wb_en = 1'b1; wb_data = dmem_rdata;  end
            OP_SW:   mem_we = 1'b1;
            OP_BEQ:  if (rd_val == rs_val) next_pc = branch_target;
            OP_BNE:  if (rd_val != rs_val) next_pc = branch_target;
            OP_JMP:  next_pc = imm12_zx;
            OP_JR:   next_pc = rs_val;
            default: ;
        endcase
    end

    // Architectural state: reset beats a load, a load stalls execution, HALT freezes.
    always_ff @(posedge CLK) begin
        if (rst) begin
            pc <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (!imem_we && !halted) begin
            pc <= next_pc;
            if (wb_en) regs[rd] <= wb_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst && imem_we) imem[imem_waddr] <= imem_wdata;
    end

    always_ff @(posedge CLK) begin
        if (!rst && !imem_we && !halted && mem_we) dmem[rs_plus_imm[DMEM_AW-1:0]] <= rd_val;
    end

    for (genvar g = 0; g < 8; g++) begin : g_reg_state
        assign reg_state[16*g +: 16] = regs[g];
    end

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: an ISA-level model predicts pc/registers/halted
// after every edge; a negedge monitor compares them against the DUT.
module tb_cpu_core;

    logic         CLK = 1'b0;
    logic         rst;
    logic         imem_we;
    logic [7:0]   imem_waddr;
    logic [15:0]  imem_wdata;
    logic         halted;
    logic [127:0] reg_state;
    logic [15:0]  pc;

    always #5 CLK = ~CLK;

    cpu_core #(.IMEM_AW(8), .DMEM_AW(8)) dut (
        .CLK(CLK), .rst(rst), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .halted(halted), .reg_state(reg_state), .pc(pc)
    );

    typedef struct {
        logic [15:0]  pc;
        logic [127:0] regs;
        logic         halt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    int m_pc;
    int m_regs[8];
    int m_imem[256];
    int m_dmem[256];
    bit m_valid = 1'b0;

    function automatic int sext(int v, int bits);
        int x = v & ((1 << bits) - 1);
        if (x >= (1 << (bits - 1))) x = x - (1 << bits);
        return x;
    endfunction

    function automatic bit m_halted();
        return ((m_imem[m_pc % 256] >> 12) & 15) == 15;
    endfunction

    function automatic int alu_ref(int fn, int a, int b);
        case (fn)
            0: return (a + b) & 'hFFFF;
            1: return (a - b) & 'hFFFF;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (a << (b % 16)) & 'hFFFF;
            6: return a >> (b % 16);
            default: return (sext(a, 16) < sext(b, 16)) ? 1 : 0;
        endcase
    endfunction

    function automatic void model_exec();
        int i   = m_imem[m_pc % 256];
        int op  = (i >> 12) & 15;
        int rd  = (i >> 9) & 7;
        int rs  = (i >> 6) & 7;
        int rt  = (i >> 3) & 7;
        int fn  = i & 7;
        int im6 = sext(i & 63, 6);
        int a   = m_regs[rs];
        int d   = m_regs[rd];
        int ea  = ((a + im6) & 'hFFFF) % 256;
        int npc = (m_pc + 1) & 'hFFFF;
        case (op)
            1: m_regs[rd] = alu_ref(fn, a, m_regs[rt]);
            2: m_regs[rd] = (a + im6) & 'hFFFF;
            3: m_regs[rd] = sext(i & 511, 9) & 'hFFFF;
            4: m_regs[rd] = m_dmem[ea];
            5: m_dmem[ea] = d;
            6: if (d == a) npc = (m_pc + 1 + im6) & 'hFFFF;
            7: if (d != a) npc = (m_pc + 1 + im6) & 'hFFFF;
            8: npc = i & 'hFFF;
            9: npc = a;
            default: ;
        endcase
        m_pc = npc;
    endfunction

    function automatic void model_step(bit r, bit we, int wa, int wd);
        if (r) begin
            m_pc = 0;
            foreach (m_regs[k]) m_regs[k] = 0;
            m_valid = 1'b1;
        end else if (we) begin
            m_imem[wa % 256] = wd & 'hFFFF;
        end else if (m_valid && !m_halted()) begin
            model_exec();
        end
    endfunction

    function automatic logic [127:0] m_regs_packed();
        logic [127:0] v = '0;
        for (int k = 0; k < 8; k++) v[16*k +: 16] = 16'(m_regs[k]);
        return v;
    endfunction

    task automatic applyStimulus(input bit r, input bit we, input int wa, input int wd);
        exp_t e;
        rst        = r;
        imem_we    = we;
        imem_waddr = 8'(wa);
        imem_wdata = 16'(wd);
        @(posedge CLK);
        model_step(r, we, wa, wd);
        if (m_valid) begin
            e.pc   = 16'(m_pc);
            e.regs = m_regs_packed();
            e.halt = m_halted();
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic load_prog(input logic [15:0] p[$], input int base);
        foreach (p[k]) applyStimulus(1'b0, 1'b1, base + k, p[k]);
    endtask

    task automatic run_until_halt(input int budget);
        int n = 0;
        while (!m_halted() && n < budget) begin
            applyStimulus(1'b0, 1'b0, 0, 0);
            n++;
        end
        checkOutput("halt_budget", 128'(m_halted()), 128'd1);
    endtask

    function automatic logic [15:0] ins_r(int op, int rd, int rs, int low6);
        return 16'((op << 12) | ((rd & 7) << 9) | ((rs & 7) << 6) | (low6 & 63));
    endfunction

    function automatic logic [15:0] ins_li(int rd, int imm9);
        return 16'((3 << 12) | ((rd & 7) << 9) | (imm9 & 511));
    endfunction

    function automatic logic [15:0] rand_instr();
        int k    = int'($urandom_range(0, 19));
        int low  = int'($urandom_range(0, 4095));
        int op;
        if (k <= 5)       op = 1;
        else if (k <= 8)  op = 2;
        else if (k <= 10) op = 3;
        else if (k <= 12) op = 4;
        else if (k <= 14) op = 5;
        else if (k == 15) op = 6;
        else if (k == 16) op = 7;
        else if (k == 17) begin op = 8; low = int'($urandom_range(0, 40)); end
        else if (k == 18) op = 9;
        else              op = int'($urandom_range(10, 15)) % 16;
        if (k == 19 && op == 15) op = 0;
        return 16'((op << 12) | low);
    endfunction

    function automatic logic [15:0] dreg(int i);
        return reg_state[16*i +: 16];
    endfunction

    // Monitor: every edge the DUT presents new state; compare it with the prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_pc", 128'(pc), 128'(e.pc));
                checkOutput("sb_regs", reg_state, e.regs);
                checkOutput("sb_halted", 128'(halted), 128'(e.halt));
            end
        end
    end

    initial begin
        logic [15:0] p[$];
        logic [15:0] p2[$];
        rst = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;

        // HALT-only memory image, then reset
        for (int a = 0; a < 256; a++) applyStimulus(1'b0, 1'b1, a, 'hF000);
        applyStimulus(1'b1, 1'b0, 0, 0);
        checkOutput("halt_reset_pc", 128'(pc), 128'd0);
        checkOutput("halt_reset_halted", 128'(halted), 128'd1);
        applyStimulus(1'b0, 1'b0, 0, 0);
        checkOutput("halt_hold_pc", 128'(pc), 128'd0);
        checkOutput("halt_hold_regs", reg_state, 128'd0);

        // Clear all of dmem with a BNE-terminated store loop
        p = '{ins_li(1, 255), ins_li(7, -1), ins_r(5, 0, 1, 0), ins_r(2, 1, 1, -1), ins_r(7, 1, 7, -3), 16'hF000};
        load_prog(p, 0);
        applyStimulus(1'b1, 1'b0, 0, 0);
        run_until_halt(1000);
        checkOutput("init_r1", 128'(dreg(1)), 128'hFFFF);

        // ADDI / NOP sequence
        p = '{16'h2001, 16'h0000, 16'h2001, 16'hF000};
        load_prog(p, 0);
        applyStimulus(1'b1, 1'b0, 0, 0);
        checkOutput("addi_pc0", 128'(pc), 128'd0);
        checkOutput("addi_halted0", 128'(halted), 128'd0);
        applyStimulus(1'b0, 1'b0, 0, 0);
        checkOutput("addi_r0_e1", 128'(dreg(0)), 128'd1);
        applyStimulus(1'b0, 1'b0, 0, 0);
        checkOutput("addi_pc_e2", 128'(pc), 128'd2);
        applyStimulus(1'b0, 1'b0, 0, 0);
        checkOutput("addi_r0_e3", 128'(dreg(0)), 128'd2);
        checkOutput("addi_halted_e3", 128'(halted), 128'd1);
        applyStimulus(1'b0, 1'b0, 0, 0);
        checkOutput("addi_pc_hold", 128'(pc), 128'd3);

        // ALU and LI
        p = '{ins_li(1, 5), ins_li(2, -3), ins_r(1, 3, 1, 16), ins_r(1, 4, 1, 17),
              ins_r(1, 5, 2, 15), ins_li(7, 4), ins_r(1, 6, 1, 61), 16'hF000};
        load_prog(p, 0);
        applyStimulus(1'b1, 1'b0, 0, 0);
        run_until_halt(20);
        checkOutput("li_neg", 128'(dreg(2)), 128'hFFFD);
        checkOutput("alu_add", 128'(dreg(3)), 128'd2);
        checkOutput("alu_sub", 128'(dreg(4)), 128'd8);
        checkOutput("alu_slt", 128'(dreg(5)), 128'd1);
        checkOutput("alu_shl", 128'(dreg(6)), 128'h50);

        // Store/load round trip, then reload after reset
        p = '{ins_li(1, 'h91), ins_li(2, 5), ins_r(1, 1, 1, 21), ins_r(2, 1, 1, 20),
              ins_r(5, 1, 0, 7), ins_r(4, 4, 0, 7), 16'hF000};
        load_prog(p, 0);
        applyStimulus(1'b1, 1'b0, 0, 0);
        run_until_halt(20);
        checkOutput("mem_lw", 128'(dreg(4)), 128'h1234);
        p = '{ins_r(4, 3, 0, 7), 16'hF000};
        load_prog(p, 0);
        applyStimulus(1'b1, 1'b0, 0, 0);
        run_until_halt(10);
        checkOutput("mem_survives_reset", 128'(dreg(3)), 128'h1234);

        // JMP, BNE loop, JR
        p  = '{ins_li(2, 5), 16'h8010, 16'h0000, 16'hF000};
        p2 = '{ins_r(2, 1, 1, 1), ins_r(7, 1, 2, -2), ins_li(5, 3), ins_r(9, 0, 5, 0)};
        load_prog(p, 0);
        load_prog(p2, 16);
        applyStimulus(1'b1, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b0, 0, 0);
        checkOutput("jmp_pc", 128'(pc), 128'd16);
        run_until_halt(50);
        checkOutput("jr_pc", 128'(pc), 128'd3);
        checkOutput("loop_count", 128'(dreg(1)), 128'd5);

        // BEQ onto itself, then HALT written under the current pc
        p = '{16'h603F};
        load_prog(p, 0);
        applyStimulus(1'b1, 1'b0, 0, 0);
        repeat (3) applyStimulus(1'b0, 1'b0, 0, 0);
        checkOutput("beq_self_pc", 128'(pc), 128'd0);
        applyStimulus(1'b0, 1'b1, 0, 'hF000);
        checkOutput("write_halt_now", 128'(halted), 128'd1);

        // Load stall mid-program, reset while halted, reset beating a write
        p = '{16'h2001, 16'h2001, 16'h2001, 16'h2001, 16'hF000};
        load_prog(p, 0);
        applyStimulus(1'b1, 1'b0, 0, 0);
        repeat (2) applyStimulus(1'b0, 1'b0, 0, 0);
        repeat (3) applyStimulus(1'b0, 1'b1, 200, 0);
        checkOutput("stall_pc", 128'(pc), 128'd2);
        checkOutput("stall_r0", 128'(dreg(0)), 128'd2);
        run_until_halt(10);
        checkOutput("stall_final_r0", 128'(dreg(0)), 128'd4);
        applyStimulus(1'b1, 1'b1, 0, 'hF000);
        checkOutput("rst_halted_pc", 128'(pc), 128'd0);
        checkOutput("rst_halted_regs", reg_state, 128'd0);
        checkOutput("rst_beats_write", 128'(halted), 128'd0);

        // Random programs with random stalls/writes/resets
        for (int t = 0; t < 20; t++) begin
            p = {};
            for (int k = 0; k < 32; k++) p.push_back(rand_instr());
            p.push_back(16'hF000);
            load_prog(p, 0);
            applyStimulus(1'b1, 1'b0, 0, 0);
            for (int c = 0; c < 60; c++) begin
                applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0,
                              int'($urandom_range(0, 63)), int'($urandom_range(0, 65535)));
            end
        end

        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
